// File: rtl/assert_pkg.sv
// Shared definitions for the step-scheduled check sequencer.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package assert_pkg;

  // Sequencer states; the codes are only compared, never decoded elsewhere.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Width needed to index v items, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fail_popcount.sv
// Counts the set bits of a per-step failure mask.
// Latency: combinational.
// Backpressure: none.
module fail_popcount #(
  parameter int NUM_CHECKS = 4,
  parameter int FC_W       = 7
) (
  input  logic [NUM_CHECKS-1:0] mask,
  output logic [FC_W-1:0]       count
);

  // Plain adder chain; NUM_CHECKS is small so no tree is needed.
  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      count = count + FC_W'(mask[i]);
    end
  end

endmodule

// File: rtl/assert_sequencer.sv
// Steps a test through NUM_STEPS indices, samples check lines after a settle delay, reports pass/fail.
// Latency: SETTLE+2 cycles per step; done NUM_STEPS*(SETTLE+2) edges after start (earlier on stop-on-fail).
// Backpressure: none; start is ignored while busy and is not queued.
module assert_sequencer
  import assert_pkg::*;
#(
  parameter  int NUM_STEPS    = 16,
  parameter  int NUM_CHECKS   = 4,
  parameter  int SETTLE       = 2,
  parameter  int STOP_ON_FAIL = 1,
  localparam int IDX_W        = clog2_min1(NUM_STEPS),
  localparam int FC_W         = $clog2(NUM_STEPS*NUM_CHECKS+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IDX_W-1:0]      step_idx,
  output logic                  step_valid,
  input  logic [NUM_CHECKS-1:0] check_en,
  input  logic [NUM_CHECKS-1:0] check_ok,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [FC_W-1:0]       fail_count,
  output logic [IDX_W-1:0]      first_fail_step,
  output logic [NUM_CHECKS-1:0] first_fail_mask
);

  localparam int             SC_W        = clog2_min1(SETTLE + 1);
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t                  state_q, state_d;
  logic [SC_W-1:0]         settle_q;
  logic [IDX_W-1:0]        idx_q;
  logic [FC_W-1:0]         fc_q;
  logic [IDX_W-1:0]        ffs_q;
  logic [NUM_CHECKS-1:0]   ffm_q;
  logic                    ff_seen_q;
  logic [NUM_CHECKS-1:0]   fail_mask;
  logic [FC_W-1:0]         fail_pop;
  logic                    last_step;

  // A line fails unless its result is exactly 1; X/Z on an enabled line counts as a failure.
  always_comb begin
    fail_mask = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      fail_mask[i] = check_en[i] & ~(check_ok[i] === 1'b1);
    end
  end

  fail_popcount #(
    .NUM_CHECKS (NUM_CHECKS),
    .FC_W       (FC_W)
  ) u_pop (
    .mask  (fail_mask),
    .count (fail_pop)
  );

  assign last_step = (idx_q == IDX_W'(NUM_STEPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one APPLY cycle, SETTLE cycles of wait, one SAMPLE cycle per step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_APPLY;
      S_APPLY:        state_d = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
      S_SETTLE:       if (settle_q == '0) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (((|fail_mask) && (STOP_ON_FAIL != 0)) || last_step) state_d = S_DONE;
        else                                                   state_d = S_APPLY;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // Settle counter, step counter and result registers; start clears all run results.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q  <= '0;
      idx_q     <= '0;
      fc_q      <= '0;
      ffs_q     <= '0;
      ffm_q     <= '0;
      ff_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_q     <= '0;
            fc_q      <= '0;
            ffs_q     <= '0;
            ffm_q     <= '0;
            ff_seen_q <= 1'b0;
          end
        end
        S_APPLY:  settle_q <= SETTLE_LOAD;
        S_SETTLE: if (settle_q != '0) settle_q <= settle_q - SC_W'(1);
        S_SAMPLE: begin
          fc_q <= fc_q + fail_pop;
          if ((|fail_mask) && !ff_seen_q) begin
            ff_seen_q <= 1'b1;
            ffs_q     <= idx_q;
            ffm_q     <= fail_mask;
          end
          if (state_d == S_APPLY) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Status outputs decode directly from state so reset forces them all low.
  always_comb begin
    step_valid = (state_q == S_APPLY);
    busy       = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    done       = (state_q == S_DONE);
    pass       = (state_q == S_DONE) && (fc_q == '0);
  end

  assign step_idx        = idx_q;
  assign fail_count      = fc_q;
  assign first_fail_step = ffs_q;
  assign first_fail_mask = ffm_q;

endmodule
